// File: rtl/game_timer_ctrl_if.sv
// ---------------------------------------------------------------------------
// game_timer_ctrl_if
// Purpose : bundles the signals between the input-side game timer block and
//           its surroundings (VGA timing, button, collision logic and the
//           level sequencer).
// Signals :
//   frame_tick  - one-cycle pulse per video frame
//   btn_raw     - asynchronous select button, active-high
//   collision   - player/obstacle overlap, level-sensitive
//   menuScreen  - level sequencer is in menu
//   winScreen   - level sequencer is in win screen
//   playerDone  - level sequencer is in final falling phase
//   game_time   - 11-bit game time count
//   userSel     - one-cycle debounced press pulse
//   playerDied  - one-cycle death pulse
// Modports: master drives the inputs of the timer block and observes its
//           outputs; slave is the timer block itself.
// ---------------------------------------------------------------------------
interface game_timer_ctrl_if;
  logic        frame_tick;
  logic        btn_raw;
  logic        collision;
  logic        menuScreen;
  logic        winScreen;
  logic        playerDone;
  logic [10:0] game_time;
  logic        userSel;
  logic        playerDied;

  modport master (
    output frame_tick, btn_raw, collision, menuScreen, winScreen, playerDone,
    input  game_time, userSel, playerDied
  );

  modport slave (
    input  frame_tick, btn_raw, collision, menuScreen, winScreen, playerDone,
    output game_time, userSel, playerDied
  );
endinterface

// File: rtl/game_timer_ctrl.sv
// ---------------------------------------------------------------------------
// game_timer_ctrl
// Purpose : produces game_time, userSel and playerDied for the level
//           sequencer. Divides frame ticks into an 11-bit saturating game
//           time, debounces the select button into one-cycle press pulses and
//           turns collision hits into a one-cycle death pulse followed
//           (optionally) by a respawn grace window.
// Ports   :
//   clk    - system clock
//   reset  - synchronous, active-high reset
//   bus    - game_timer_ctrl_if.slave (frame_tick, btn_raw, collision,
//            menuScreen, winScreen, playerDone in; game_time, userSel,
//            playerDied out)
// Parameters:
//   TICK_DIV     - frame ticks per game_time increment (>=1)
//   DEB_CYCLES   - stable clk cycles needed to accept a button change (>=1)
//   GRACE_FRAMES - frame ticks of collision immunity after a death (>=1)
// Build option:
//   GAME_TIMER_GRACE_EN - when defined, DEAD is followed by a GRACE window of
//   GRACE_FRAMES ticks in which collisions are ignored; when undefined DEAD
//   returns straight to RUN and GRACE_FRAMES is unused.
// ---------------------------------------------------------------------------
module game_timer_ctrl #(
  parameter int TICK_DIV     = 6,
  parameter int DEB_CYCLES   = 500000,
  parameter int GRACE_FRAMES = 60
) (
  input  logic               clk,
  input  logic               reset,
  game_timer_ctrl_if.slave   bus
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_DONE = DEB_W'(DEB_CYCLES);
  localparam logic [10:0]      GT_MAX   = 11'd2047;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DEAD  = 2'd2,
    ST_GRACE = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Button path: 2-FF synchronizer, debounce, rising-edge pulse
  // -------------------------------------------------------------------------
  logic             btn_meta_q;
  logic             btn_sync_q;
  logic             btn_acc_q;
  logic             btn_acc_prev_q;
  logic             user_sel_q;
  logic [DEB_W-1:0] deb_cnt_q;
  logic [DEB_W-1:0] deb_cnt_inc;

  assign deb_cnt_inc = deb_cnt_q + DEB_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_meta_q     <= 1'b0;
      btn_sync_q     <= 1'b0;
      btn_acc_q      <= 1'b0;
      btn_acc_prev_q <= 1'b0;
      user_sel_q     <= 1'b0;
      deb_cnt_q      <= '0;
    end else begin
      btn_meta_q     <= bus.btn_raw;
      btn_sync_q     <= btn_meta_q;
      btn_acc_prev_q <= btn_acc_q;
      // Pulse is registered one cycle after the accepted level rises.
      user_sel_q     <= btn_acc_q & ~btn_acc_prev_q;
      if (btn_sync_q == btn_acc_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_inc == DEB_DONE) begin
        btn_acc_q <= btn_sync_q;
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_inc;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Timer FSM
  // -------------------------------------------------------------------------
  state_t           state_q;
  state_t           state_d;
  logic             exit_req;
  logic             hit;
  logic             count_en;
  logic             clear_cnt;
  logic             player_died;
  logic [DIV_W-1:0] div_q;
  logic [10:0]      gt_q;

  assign exit_req = bus.menuScreen | bus.winScreen;
  // The falling phase has its own hit logic, so collisions are masked there.
  assign hit      = bus.collision & ~bus.playerDone;

`ifdef GAME_TIMER_GRACE_EN
  localparam int GR_W = (GRACE_FRAMES > 1) ? $clog2(GRACE_FRAMES) : 1;
  localparam logic [GR_W-1:0] GR_LAST = GR_W'(GRACE_FRAMES - 1);

  logic [GR_W-1:0] grace_q;
  logic            grace_done;

  assign grace_done = bus.frame_tick & (grace_q == GR_LAST);

  // Grace counter only runs inside GRACE; it is zero on every entry.
  always_ff @(posedge clk) begin
    if (reset || exit_req || (state_q != ST_GRACE)) begin
      grace_q <= '0;
    end else if (bus.frame_tick) begin
      grace_q <= grace_done ? '0 : grace_q + GR_W'(1);
    end
  end
`else
  logic unused_grace;
  assign unused_grace = (GRACE_FRAMES > 0);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: leaving play to menu/win outranks death
  always_comb begin
    state_d = state_q;
    if (exit_req) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_RUN;
        ST_RUN:  if (hit) state_d = ST_DEAD;
`ifdef GAME_TIMER_GRACE_EN
        ST_DEAD:  state_d = ST_GRACE;
        ST_GRACE: if (grace_done) state_d = ST_RUN;
`else
        ST_DEAD: state_d = ST_RUN;
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    player_died = (state_q == ST_DEAD);
  end

  // Counting is suppressed on the cycle a hit is taken, so a tick that
  // coincides with a death is discarded.
  always_comb begin
    count_en = 1'b0;
    if (!exit_req) begin
      if ((state_q == ST_RUN) && !hit) count_en = 1'b1;
`ifdef GAME_TIMER_GRACE_EN
      if (state_q == ST_GRACE) count_en = 1'b1;
`endif
    end
  end

  assign clear_cnt = exit_req | (state_q == ST_IDLE) | (state_q == ST_DEAD);

  // Divider and game time; increments by one per division and saturates.
  always_ff @(posedge clk) begin
    if (reset || clear_cnt) begin
      div_q <= '0;
      gt_q  <= '0;
    end else if (count_en && bus.frame_tick) begin
      if (div_q == DIV_LAST) begin
        div_q <= '0;
        if (gt_q != GT_MAX) gt_q <= gt_q + 11'd1;
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

  assign bus.game_time  = gt_q;
  assign bus.userSel    = user_sel_q;
  assign bus.playerDied = player_died;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_timer_ctrl
// Self-checking bench for game_timer_ctrl. A behavioural reference model
// (game time as total ticks divided down, button as a sample-delay queue plus
// a run length of disagreeing samples) predicts the outputs after every clock
// edge; directed scenarios are followed by a randomized stretch.
// ---------------------------------------------------------------------------
module tb_game_timer_ctrl;
  localparam int TD = 2;
  localparam int DB = 4;
  localparam int GF = 3;
`ifdef GAME_TIMER_GRACE_EN
  localparam bit GRACE_EN = 1'b1;
`else
  localparam bit GRACE_EN = 1'b0;
`endif

  localparam int P_IDLE  = 0;
  localparam int P_RUN   = 1;
  localparam int P_DEAD  = 2;
  localparam int P_GRACE = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  game_timer_ctrl_if bus ();

  game_timer_ctrl #(
    .TICK_DIV    (TD),
    .DEB_CYCLES  (DB),
    .GRACE_FRAMES(GF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- reference model ----------------
  int m_phase = P_IDLE;
  int m_ticks = 0;
  int m_grace = 0;
  bit m_hist[$];
  bit m_acc   = 1'b0;
  int m_run   = 0;
  bit m_rose  = 1'b0;
  int exp_gt   = 0;
  bit exp_usel = 1'b0;
  bit exp_died = 1'b0;

  function automatic int min_gt(input int t);
    return (t / TD > 2047) ? 2047 : t / TD;
  endfunction

  task automatic model_edge();
    bit seen;
    if (reset) begin
      m_phase = P_IDLE; m_ticks = 0; m_grace = 0;
      m_hist = '{1'b0, 1'b0};
      m_acc = 1'b0; m_run = 0; m_rose = 1'b0;
      exp_gt = 0; exp_usel = 1'b0; exp_died = 1'b0;
      return;
    end
    // button: synchronized value is the raw sample from two edges ago
    exp_usel = m_rose;
    m_rose   = 1'b0;
    seen     = m_hist.pop_front();
    m_hist.push_back(bus.btn_raw);
    if (seen != m_acc) begin
      m_run++;
      if (m_run == DB) begin
        m_acc = seen; m_rose = seen; m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    // timer
    if (bus.menuScreen || bus.winScreen) begin
      m_phase = P_IDLE; m_ticks = 0; m_grace = 0;
    end else begin
      case (m_phase)
        P_IDLE: m_phase = P_RUN;
        P_RUN: begin
          if (bus.collision && !bus.playerDone) m_phase = P_DEAD;
          else if (bus.frame_tick && m_ticks < 100000) m_ticks++;
        end
        P_DEAD: begin
          m_ticks = 0; m_grace = 0;
          m_phase = GRACE_EN ? P_GRACE : P_RUN;
        end
        default: begin
          if (bus.frame_tick) begin
            m_ticks++; m_grace++;
            if (m_grace == GF) begin m_phase = P_RUN; m_grace = 0; end
          end
        end
      endcase
    end
    exp_gt   = min_gt(m_ticks);
    exp_died = (m_phase == P_DEAD);
  endtask

  // One clock: model follows the edge, outputs checked on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("game_time", {21'd0, bus.game_time}, exp_gt);
    chk("userSel", {31'd0, bus.userSel}, {31'd0, exp_usel});
    chk("playerDied", {31'd0, bus.playerDied}, {31'd0, exp_died});
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_tick = 1'b1; cycle();
      bus.frame_tick = 1'b0; cycle();
    end
  endtask

  int seen_cnt [0:7];
  int pulses;
  int died_cnt;
  int last_gt;
  int lat;

  initial begin
    bus.frame_tick = 1'b0; bus.btn_raw = 1'b0; bus.collision = 1'b0;
    bus.menuScreen = 1'b0; bus.winScreen = 1'b0; bus.playerDone = 1'b0;
    m_hist = '{1'b0, 1'b0};
    @(negedge clk);

    // 1. reset, menu hold, then counting
    reset = 1'b1; cycle(); cycle();
    reset = 1'b0;
    bus.menuScreen = 1'b1;
    tick_n(10);
    chk("menu_hold_gt", {21'd0, bus.game_time}, 0);
    bus.menuScreen = 1'b0; cycle();
    for (int i = 0; i < 8; i++) seen_cnt[i] = 0;
    last_gt = 0;
    for (int i = 0; i < 10; i++) begin
      bus.frame_tick = 1'b1; cycle();
      bus.frame_tick = 1'b0; cycle();
      if (bus.game_time != 11'(last_gt)) begin
        last_gt = int'(bus.game_time);
        if (last_gt < 8) seen_cnt[last_gt]++;
      end
    end
    chk("gt_after_10_ticks", {21'd0, bus.game_time}, 5);
    for (int v = 1; v <= 5; v++) chk("gt_value_seen_once", seen_cnt[v], 1);
    $display("scenario count: game_time=%0d", bus.game_time);

    // 2. button with bounce
    bus.btn_raw = 1'b1; cycle();
    bus.btn_raw = 1'b0; cycle();
    bus.btn_raw = 1'b1;
    pulses = 0; lat = 0;
    for (int i = 1; i <= 14; i++) begin
      cycle();
      if (bus.userSel) begin pulses++; lat = i; end
    end
    chk("usel_pulses_press", pulses, 1);
    chk("usel_latency", lat, 7);
    bus.btn_raw = 1'b0; pulses = 0;
    for (int i = 0; i < 14; i++) begin
      cycle();
      if (bus.userSel) pulses++;
    end
    chk("usel_pulses_release", pulses, 0);
    $display("scenario button: latency=%0d", lat);

    // 3. death at game_time 5, then collisions around the grace window
    bus.collision = 1'b1; cycle();
    bus.collision = 1'b0;
    chk("died_pulse", {31'd0, bus.playerDied}, 1);
    chk("gt_in_dead", {21'd0, bus.game_time}, 5);
    cycle();
    chk("gt_after_dead", {21'd0, bus.game_time}, 0);
    for (int i = 0; i < 3; i++) begin
      bus.collision = 1'b1; bus.frame_tick = 1'b1; cycle();
      bus.frame_tick = 1'b0; cycle();
      bus.collision = 1'b0; cycle(); cycle();
    end
    bus.collision = 1'b1; cycle();
    bus.collision = 1'b0; cycle(); cycle(); cycle();
    $display("scenario death: game_time=%0d", bus.game_time);

    // 4. collision and tick in the same cycle at game_time 3, divider 1
    bus.menuScreen = 1'b1; cycle(); bus.menuScreen = 1'b0; cycle();
    tick_n(7);
    chk("gt_before_same_cycle", {21'd0, bus.game_time}, 3);
    bus.collision = 1'b1; bus.frame_tick = 1'b1; cycle();
    bus.collision = 1'b0; bus.frame_tick = 1'b0;
    chk("same_cycle_died", {31'd0, bus.playerDied}, 1);
    chk("same_cycle_no_inc", {21'd0, bus.game_time}, 3);
    cycle();
    chk("same_cycle_gt_zero", {21'd0, bus.game_time}, 0);
    $display("scenario tick+collision: game_time=%0d", bus.game_time);

    // 5. saturation
    for (int i = 0; i < 8; i++) cycle();
    bus.frame_tick = 1'b1;
    for (int i = 0; i < 4200; i++) cycle();
    bus.frame_tick = 1'b0; cycle();
    chk("gt_saturated", {21'd0, bus.game_time}, 2047);
    $display("scenario saturation: game_time=%0d", bus.game_time);

    // 6. playerDone masks collisions; reset mid-grace
    bus.playerDone = 1'b1; bus.collision = 1'b1; died_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      bus.frame_tick = i[0]; cycle();
      if (bus.playerDied) died_cnt++;
    end
    bus.frame_tick = 1'b0;
    chk("done_no_death", died_cnt, 0);
    bus.playerDone = 1'b0; bus.collision = 1'b0; cycle();
    bus.collision = 1'b1; cycle();
    bus.collision = 1'b0; cycle();
    tick_n(1);
    reset = 1'b1; cycle();
    reset = 1'b0;
    chk("rst_gt", {21'd0, bus.game_time}, 0);
    chk("rst_died", {31'd0, bus.playerDied}, 0);
    chk("rst_usel", {31'd0, bus.userSel}, 0);
    bus.frame_tick = 1'b1; cycle(); bus.frame_tick = 1'b0;
    chk("idle_after_rst", {21'd0, bus.game_time}, 0);
    $display("scenario done/reset: game_time=%0d", bus.game_time);

    // 7. randomized stretch
    for (int i = 0; i < 3000; i++) begin
      bus.frame_tick = ($urandom_range(0, 2) == 0);
      bus.collision  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) bus.btn_raw = ~bus.btn_raw;
      if ($urandom_range(0, 29) == 0) bus.playerDone = ~bus.playerDone;
      if (bus.menuScreen) bus.menuScreen = ($urandom_range(0, 4) != 0);
      else bus.menuScreen = ($urandom_range(0, 149) == 0);
      bus.winScreen = ($urandom_range(0, 299) == 0);
      reset = ($urandom_range(0, 399) == 0);
      cycle();
    end
    reset = 1'b0;
    $display("scenario random: 3000 cycles");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
